// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver.
//
// Recovers bytes from an asynchronous serial line by mid-bit sampling.
// A clock-cycle counter measures bit periods. Each received byte is
// presented with a one-cycle valid strobe.
//
// Parameters
//   CLKS_PER_BIT  osc_clk cycles per serial bit (4..65535)
//
// Ports
//   osc_clk      in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   i_Rx_Serial  in   asynchronous serial input, idles high
//   o_Rx_DV      out  one-cycle pulse, o_Rx_Byte holds a new valid byte
//   o_Rx_Byte    out  last valid byte, held between frames
//   o_Rx_Active  out  high from start-bit detection until back in IDLE
//   o_Frame_Err  out  one-cycle pulse, stop bit sampled low
module uart_rx #(
  parameter int CLKS_PER_BIT = 1155
) (
  input  logic       osc_clk,
  input  logic       rstn,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic [15:0] clk_cnt_q;
  logic [15:0] clk_cnt_d;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  byte_q;
  logic        dv_q;
  logic        active_q;
  logic        ferr_q;

  assign clk_cnt_d = clk_cnt_q + 16'd1;

  always_ff @(posedge osc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      // The synchronizer resets to the idle line level, so reset release
      // cannot be mistaken for a start bit.
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      active_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      // Both strobes are single-cycle. The assignments below can only
      // raise them in the stop-bit sampling cycle.
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_s_q) begin
            state_q  <= START;
            active_q <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt_q == HALF) begin
            clk_cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
            end else begin
              // The line went high again before mid start bit, so the low was
              // a glitch and no frame is reported.
              state_q  <= IDLE;
              active_q <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_d;
          end
        end

        DATA: begin
          if (clk_cnt_q == LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_d;
          end
        end

        STOP: begin
          if (clk_cnt_q == LAST) begin
            clk_cnt_q <= '0;
            state_q   <= CLEANUP;
            if (rx_s_q) begin
              byte_q <= shift_q;
              dv_q   <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_d;
          end
        end

        CLEANUP: begin
          // Hold here while the line is low (break or stuck line). A long low
          // must not be taken as the start of a new frame.
          if (rx_s_q) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Active = active_q;
  assign o_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- bench for uart_rx with CLKS_PER_BIT=16.
// A serial frame driver pushes the expected outcome of each frame into a
// queue. An independent monitor pops the queue and compares whenever the
// receiver strobes o_Rx_DV or o_Frame_Err.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       osc_clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       active;
  logic       ferr;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         fall_cyc = 0;
  int         dv_cyc   = 0;
  logic [7:0] last_good;
  logic       prev_active = 1'b0;
  logic       frame_open  = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .osc_clk    (osc_clk),
    .rstn       (rstn),
    .i_Rx_Serial(rx),
    .o_Rx_DV    (dv),
    .o_Rx_Byte  (rx_byte),
    .o_Rx_Active(active),
    .o_Frame_Err(ferr)
  );

  always #5 osc_clk = ~osc_clk;

  always @(posedge osc_clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge osc_clk) begin
    if (!rstn) begin
      frame_open  = 1'b0;
      prev_active = 1'b0;
    end else begin
      if (active && !prev_active) frame_open = 1'b1;
      prev_active = active;
      if (dv && ferr) begin
        checks++;
        failures++;
        $display("FAIL strobe_overlap: dv=%0b ferr=%0b, required not both high", dv, ferr);
      end
      if (dv || ferr) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: dv=%0b ferr=%0b byte=%02h, required no event",
                   dv, ferr, rx_byte);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (ferr !== e.err || rx_byte !== e.b) begin
            failures++;
            $display("FAIL event: got err=%0b byte=%02h, required err=%0b byte=%02h",
                     ferr, rx_byte, e.err, e.b);
          end
        end
        checks++;
        if (!frame_open || !active) begin
          failures++;
          $display("FAIL active_frame: active=%0b rise_seen=%0b, required 1/1",
                   active, frame_open);
        end
        frame_open = 1'b0;
        if (dv) dv_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Drives the first nbits of a frame {stop, data[7:0] LSB first, start}.
  // It starts and ends on a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      if (i == 0) fall_cyc = cyc;
      repeat (CPB) @(negedge osc_clk);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back('{err: 1'b0, b: d});
    last_good = d;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge osc_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d events outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0] d;
    int gap;
    rstn      = 1'b0;
    rx        = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge osc_clk);
    chk("reset_dv", 32'(dv), 32'd0);
    chk("reset_byte", 32'(rx_byte), 32'h00);
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_ferr", 32'(ferr), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge osc_clk);

    // 1: single frame 0xA5, with a latency check.
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1, 10);
    wait_drain("t1_drain");
    chk("t1_latency_ok", 32'((dv_cyc - fall_cyc >= 154) && (dv_cyc - fall_cyc <= 156)), 32'd1);
    chk("t1_active_idle", 32'(active), 32'd0);
    repeat (10) @(negedge osc_clk);

    // 2: back-to-back 0x00 then 0xFF with no idle time.
    expect_byte(8'h00);
    send_frame(8'h00, 1'b1, 10);
    expect_byte(8'hFF);
    send_frame(8'hFF, 1'b1, 10);
    wait_drain("t2_drain");
    repeat (10) @(negedge osc_clk);

    // 3: a 5-clock glitch must be rejected.
    rx = 1'b0;
    repeat (5) @(negedge osc_clk);
    rx = 1'b1;
    repeat (7) @(negedge osc_clk);
    chk("t3_active_cleared", 32'(active), 32'd0);
    repeat (30) @(negedge osc_clk);

    // 4: stop bit low, then the line is held low for 40 clocks.
    exp_q.push_back('{err: 1'b1, b: last_good});
    send_frame(8'h3C, 1'b0, 10);
    repeat (40) @(negedge osc_clk);
    chk("t4_active_held", 32'(active), 32'd1);
    chk("t4_byte_kept", 32'(rx_byte), 32'hFF);
    rx = 1'b1;
    repeat (6) @(negedge osc_clk);
    chk("t4_active_released", 32'(active), 32'd0);
    wait_drain("t4_drain");
    repeat (10) @(negedge osc_clk);

    // 5: reset during bit 4 of 0x81, then receive 0x42.
    send_frame(8'h81, 1'b1, 5);
    rx = 1'b0;
    repeat (8) @(negedge osc_clk);
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge osc_clk);
    chk("t5_reset_dv", 32'(dv), 32'd0);
    chk("t5_reset_byte", 32'(rx_byte), 32'h00);
    chk("t5_reset_active", 32'(active), 32'd0);
    chk("t5_reset_ferr", 32'(ferr), 32'd0);
    rstn      = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge osc_clk);
    expect_byte(8'h42);
    send_frame(8'h42, 1'b1, 10);
    wait_drain("t5_drain");
    chk("t5_byte", 32'(rx_byte), 32'h42);
    repeat (10) @(negedge osc_clk);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 20);
      expect_byte(d);
      send_frame(d, 1'b1, 10);
      repeat (gap) @(negedge osc_clk);
    end
    wait_drain("rand_drain");

    // 6: 256 sequential bytes, back to back, as a transmitter would send them.
    for (int i = 0; i < 256; i++) begin
      expect_byte(8'(i));
      send_frame(8'(i), 1'b1, 10);
    end
    wait_drain("t6_drain");
    repeat (20) @(negedge osc_clk);
    chk("final_active", 32'(active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
